// File: rtl/bp_pkg.sv
// Shared types, direction-counter encodings and address slicing helpers
// for the fetch-stage branch predictor.
package bp_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Generic weak encodings for any counter width up to 8 bits.
  function automatic logic [7:0] weak_t(input int n);
    return 8'(1) << (n - 1);
  endfunction

  function automatic logic [7:0] weak_nt(input int n);
    return (8'(1) << (n - 1)) - 8'd1;
  endfunction

  // Entry layout for the default geometry (WIDTH=32, ENTRIES=16, CNT_BITS=2).
  typedef struct packed {
    logic        valid;
    logic [25:0] tag;
    logic [31:0] target;
    logic        jump;
    logic [1:0]  cnt;
  } bp_entry_t;

  function automatic logic [31:0] bp_idx(input logic [63:0] pc, input int idx_w);
    return 32'((pc >> 2) & ((64'd1 << idx_w) - 64'd1));
  endfunction

  function automatic logic [63:0] bp_tag(input logic [63:0] pc, input int idx_w);
    return pc >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Combinational next-value logic for a saturating up/down counter with a
// priority load.
module sat_counter #(
  parameter int CNT_BITS = 2
) (
  input  logic [CNT_BITS-1:0] i_cnt,
  input  logic                i_inc,
  input  logic                i_dec,
  input  logic                i_load,
  input  logic [CNT_BITS-1:0] i_load_val,
  output logic [CNT_BITS-1:0] o_next
);

  always_comb begin
    o_next = i_cnt;
    if (i_load)
      o_next = i_load_val;
    else if (i_inc && !(&i_cnt))
      o_next = i_cnt + CNT_BITS'(1);
    else if (i_dec && (|i_cnt))
      o_next = i_cnt - CNT_BITS'(1);
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry direction counters: zero-latency lookup
// from IF, training from ID, plus lookup/mispredict performance counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int ENTRIES  = 16,
  parameter int CNT_BITS = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] if_pc,
  input  logic             lookup_en,
  output logic             pred_taken,
  output logic [WIDTH-1:0] pred_target,
  input  logic             upd_valid,
  input  logic [WIDTH-1:0] upd_pc,
  input  logic             upd_is_jump,
  input  logic             upd_taken,
  input  logic [WIDTH-1:0] upd_target,
  input  logic             upd_mispredict,
  input  logic             flush_all,
  output logic [31:0]      cnt_lookup,
  output logic [31:0]      cnt_mispredict
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = WIDTH - IDX - 2;
  localparam logic [7:0] WT8  = weak_t(CNT_BITS);
  localparam logic [7:0] WNT8 = weak_nt(CNT_BITS);
  localparam logic [CNT_BITS-1:0] CNT_WT  = WT8[CNT_BITS-1:0];
  localparam logic [CNT_BITS-1:0] CNT_WNT = WNT8[CNT_BITS-1:0];

  typedef struct packed {
    logic                valid;
    logic [TAG_W-1:0]    tag;
    logic [WIDTH-1:0]    target;
    logic                jump;
    logic [CNT_BITS-1:0] cnt;
  } entry_t;

  entry_t r_tbl [ENTRIES];
  logic [31:0] r_cnt_lookup;
  logic [31:0] r_cnt_mis;

  logic [IDX-1:0]      w_lk_idx;
  logic [TAG_W-1:0]    w_lk_tag;
  logic                w_lk_hit;
  logic [IDX-1:0]      w_up_idx;
  logic [TAG_W-1:0]    w_up_tag;
  logic                w_up_hit;
  logic                w_up_we;
  logic [CNT_BITS-1:0] w_cnt_nxt;

  assign w_lk_idx = IDX'(bp_idx(64'(if_pc), IDX));
  assign w_lk_tag = TAG_W'(bp_tag(64'(if_pc), IDX));
  assign w_up_idx = IDX'(bp_idx(64'(upd_pc), IDX));
  assign w_up_tag = TAG_W'(bp_tag(64'(upd_pc), IDX));

  // Lookup reads only registered state, so a same-cycle update is not seen.
  assign w_lk_hit    = r_tbl[w_lk_idx].valid && (r_tbl[w_lk_idx].tag == w_lk_tag);
  assign pred_taken  = w_lk_hit && (r_tbl[w_lk_idx].jump || r_tbl[w_lk_idx].cnt[CNT_BITS-1]);
  assign pred_target = pred_taken ? r_tbl[w_lk_idx].target : if_pc + WIDTH'(4);

  assign w_up_hit = r_tbl[w_up_idx].valid && (r_tbl[w_up_idx].tag == w_up_tag);
  assign w_up_we  = upd_valid && (upd_taken || w_up_hit);

  sat_counter #(.CNT_BITS(CNT_BITS)) u_sat_counter (
    .i_cnt      (r_tbl[w_up_idx].cnt),
    .i_inc      (w_up_hit && upd_taken),
    .i_dec      (w_up_hit && !upd_taken),
    .i_load     (!w_up_hit && upd_taken),
    .i_load_val (upd_is_jump ? {CNT_BITS{1'b1}} : CNT_WT),
    .o_next     (w_cnt_nxt)
  );

  // Tags, targets and jump flags are only meaningful behind a valid bit,
  // so reset leaves them alone.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_tbl[i].valid <= 1'b0;
        r_tbl[i].cnt   <= CNT_WNT;
      end
      r_cnt_lookup <= '0;
      r_cnt_mis    <= '0;
    end else begin
      if (lookup_en)
        r_cnt_lookup <= r_cnt_lookup + 32'd1;
      if (upd_valid && upd_mispredict)
        r_cnt_mis <= r_cnt_mis + 32'd1;
      if (flush_all) begin
        for (int i = 0; i < ENTRIES; i++)
          r_tbl[i].valid <= 1'b0;
      end else if (w_up_we) begin
        r_tbl[w_up_idx].cnt <= w_cnt_nxt;
        if (upd_taken) begin
          r_tbl[w_up_idx].valid  <= 1'b1;
          r_tbl[w_up_idx].tag    <= w_up_tag;
          r_tbl[w_up_idx].target <= upd_target;
          r_tbl[w_up_idx].jump   <= upd_is_jump;
        end
      end
    end
  end

  assign cnt_lookup     = r_cnt_lookup;
  assign cnt_mispredict = r_cnt_mis;

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized and directed bench for branch_predictor against a behavioural
// BTB model kept as plain per-slot arrays keyed by the owning PC.
module tb_branch_predictor;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] if_pc = '0;
  logic        lookup_en = 1'b0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_is_jump = 1'b0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_mispredict = 1'b0;
  logic        flush_all = 1'b0;
  logic [31:0] cnt_lookup;
  logic [31:0] cnt_mispredict;

  branch_predictor #(.WIDTH(32), .ENTRIES(16), .CNT_BITS(2)) dut (
    .CLK(CLK), .RST(RST), .if_pc(if_pc), .lookup_en(lookup_en),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispredict(upd_mispredict), .flush_all(flush_all),
    .cnt_lookup(cnt_lookup), .cnt_mispredict(cnt_mispredict)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_pass = 0;

  // Model: one slot per index, remembering which PC owns it.
  bit          m_v   [16];
  int unsigned m_own [16];
  int unsigned m_tg  [16];
  bit          m_j   [16];
  int          m_c   [16];
  int unsigned m_lk;
  int unsigned m_mis;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int slot(input int unsigned pc);
    return (pc / 4) % 16;
  endfunction

  function automatic bit m_hit(input int unsigned pc);
    int s = slot(pc);
    return m_v[s] && ((m_own[s] / 64) == (pc / 64));
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_v[i] = 0;
      m_c[i] = 1;
    end
    m_lk = 0;
    m_mis = 0;
  endtask

  task automatic m_predict(input int unsigned pc, output bit t, output int unsigned tg);
    int s = slot(pc);
    t  = m_hit(pc) && (m_j[s] || m_c[s] >= 2);
    tg = t ? m_tg[s] : pc + 4;
  endtask

  task automatic m_update(input int unsigned pc, input bit j, input bit t,
                          input int unsigned tg, input bit fl);
    int s = slot(pc);
    if (fl) begin
      for (int i = 0; i < 16; i++) m_v[i] = 0;
    end else if (m_hit(pc)) begin
      if (t) begin
        m_c[s]  = (m_c[s] < 3) ? m_c[s] + 1 : 3;
        m_tg[s] = tg;
        m_j[s]  = j;
      end else begin
        m_c[s] = (m_c[s] > 0) ? m_c[s] - 1 : 0;
      end
    end else if (t) begin
      m_v[s]   = 1;
      m_own[s] = pc;
      m_tg[s]  = tg;
      m_j[s]   = j;
      m_c[s]   = j ? 3 : 2;
    end
  endtask

  // Entered just after a falling edge; returns after the next falling edge.
  task automatic cycle(input logic [31:0] pc, input bit len, input bit uv,
                       input logic [31:0] upc, input bit uj, input bit ut,
                       input logic [31:0] utg, input bit um, input bit fl);
    bit et;
    int unsigned etg;
    if_pc = pc; lookup_en = len; upd_valid = uv; upd_pc = upc;
    upd_is_jump = uj; upd_taken = ut; upd_target = utg;
    upd_mispredict = um; flush_all = fl;
    #1;
    m_predict(pc, et, etg);
    chk("pred_taken", {63'd0, pred_taken}, {63'd0, et});
    chk("pred_target", {32'd0, pred_target}, {32'd0, etg});
    chk("cnt_lookup", {32'd0, cnt_lookup}, {32'd0, m_lk});
    chk("cnt_mispredict", {32'd0, cnt_mispredict}, {32'd0, m_mis});
    @(posedge CLK);
    if (uv || fl) m_update(upc, uj || ut ? (uj) : 1'b0, uj ? 1'b1 : ut, utg, fl && 1'b1 ? fl : 1'b0);
    if (len) m_lk++;
    if (uv && um) m_mis++;
    @(negedge CLK);
    upd_valid = 0; flush_all = 0; lookup_en = 0; upd_mispredict = 0;
  endtask

  task automatic upd(input logic [31:0] upc, input bit uj, input bit ut, input logic [31:0] utg);
    cycle(32'h0, 1'b0, 1'b1, upc, uj, ut, utg, 1'b0, 1'b0);
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input bit et, input logic [31:0] etg);
    if_pc = pc;
    #1;
    chk({tag, "_taken"}, {63'd0, pred_taken}, {63'd0, et});
    chk({tag, "_target"}, {32'd0, pred_target}, {32'd0, etg});
  endtask

  task automatic async_reset(input string tag);
    if_pc = 32'h40;
    #2 RST = 1'b0;
    #1;
    chk({tag, "_cnt_lookup"}, {32'd0, cnt_lookup}, 64'd0);
    chk({tag, "_cnt_mis"}, {32'd0, cnt_mispredict}, 64'd0);
    chk({tag, "_pred_taken"}, {63'd0, pred_taken}, 64'd0);
    chk({tag, "_pred_target"}, {32'd0, pred_target}, 64'h44);
    m_reset();
    @(negedge CLK);
    RST = 1'b1;
  endtask

  initial begin
    m_reset();
    if_pc = 32'h40;
    #1;
    chk("rst_pred_taken", {63'd0, pred_taken}, 64'd0);
    chk("rst_pred_target", {32'd0, pred_target}, 64'h44);
    chk("rst_cnt_lookup", {32'd0, cnt_lookup}, 64'd0);
    @(negedge CLK);
    RST = 1'b1;

    // Conditional branch training and saturation at zero
    upd(32'h40, 0, 1, 32'h100);
    look("alloc", 32'h40, 1, 32'h100);
    upd(32'h40, 0, 0, 32'h0);
    look("wt_to_wnt", 32'h40, 0, 32'h44);
    upd(32'h40, 0, 0, 32'h0);
    upd(32'h40, 0, 0, 32'h0);
    upd(32'h40, 0, 0, 32'h0);
    upd(32'h40, 0, 1, 32'h100);
    look("sat_zero", 32'h40, 0, 32'h44);

    // Jump stays predicted taken; it also evicts 0x40 (same index)
    upd(32'h80, 1, 1, 32'h200);
    look("jump", 32'h80, 1, 32'h200);
    look("alias", 32'h40, 0, 32'h44);
    upd(32'h80, 0, 0, 32'h0);
    upd(32'h80, 0, 0, 32'h0);
    upd(32'h80, 0, 0, 32'h0);
    look("jump_sticky", 32'h80, 1, 32'h200);

    // Flush beats a same-cycle allocate
    cycle(32'h0, 0, 1, 32'hC4, 0, 1, 32'h500, 0, 1);
    look("flush_old", 32'h80, 0, 32'h84);
    look("flush_new", 32'hC4, 0, 32'hC8);

    // Same-cycle lookup and update of one index sees old contents
    if_pc = 32'h40; upd_valid = 1; upd_pc = 32'h40; upd_is_jump = 0;
    upd_taken = 1; upd_target = 32'h300;
    #1;
    chk("same_cycle_taken", {63'd0, pred_taken}, 64'd0);
    chk("same_cycle_target", {32'd0, pred_target}, 64'h44);
    @(posedge CLK);
    m_update(32'h40, 0, 1, 32'h300, 0);
    @(negedge CLK);
    upd_valid = 0;
    look("next_cycle", 32'h40, 1, 32'h300);

    // Performance counters
    async_reset("rst1");
    cycle(32'h0, 1, 1, 32'h10, 0, 0, 0, 1, 0);
    cycle(32'h0, 1, 1, 32'h14, 0, 0, 0, 1, 0);
    cycle(32'h0, 1, 0, 32'h18, 0, 0, 0, 1, 0);
    cycle(32'h0, 1, 1, 32'h1C, 0, 0, 0, 1, 0);
    cycle(32'h0, 1, 0, 32'h0, 0, 0, 0, 0, 0);
    #1;
    chk("perf_lookup", {32'd0, cnt_lookup}, 64'd5);
    chk("perf_mis", {32'd0, cnt_mispredict}, 64'd3);
    async_reset("rst2");

    // Randomized traffic over a small aliasing address space
    for (int n = 0; n < 500; n++) begin
      logic [31:0] pc, upc, tg;
      bit uj, ut;
      pc  = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      upc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      tg  = $urandom & 32'hFFFF_FFFC;
      uj  = ($urandom_range(0, 4) == 0);
      ut  = uj ? 1'b1 : $urandom_range(0, 1);
      cycle(pc, $urandom_range(0, 1), $urandom_range(0, 3) != 0, upc, uj, ut, tg,
            $urandom_range(0, 1), $urandom_range(0, 40) == 0);
      if (n == 250) async_reset("rst_rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
